column_draw_task: RTL
=====================

Name: column_draw_task

Overview:
- Responder/executor for the clkb end of the cross-domain task handshake.
- Accepts a one-cycle task_start pulse, latches the column parameters, and writes one full screen column (ceiling, wall span, floor) into the framebuffer write port.
- Returns a one-cycle task_done pulse when finished.
- Sits between the clkb-side start/done signals of the task synchroniser and the framebuffer memory.

Parameters:
- SCREEN_W, 320, framebuffer width in pixels (row stride).
- SCREEN_H, 240, framebuffer height in pixels (column length).
- ADDR_W, 17, framebuffer address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H.
- COLOR_W, 8, pixel width.

Ports:
- clk, in, 1, single clock (the clkb domain).
- rst_n, in, 1, synchronous active-low reset.
- task_start, in, 1, one-cycle start pulse from the synchroniser's clkb start output.
- task_done, out, 1, one-cycle completion pulse to the synchroniser's clkb done input.
- busy, out, 1, high while a column is in progress.
- col_x, in, 9, target column; sampled on an accepted start.
- wall_h, in, 9, wall span height in pixels; sampled on an accepted start.
- ceil_color, in, COLOR_W, ceiling colour; sampled on an accepted start.
- wall_color, in, COLOR_W, wall colour; sampled on an accepted start.
- floor_color, in, COLOR_W, floor colour; sampled on an accepted start.
- fb_addr, out, ADDR_W, framebuffer write address.
- fb_data, out, COLOR_W, framebuffer write data.
- fb_we, out, 1, write request.
- fb_ready, in, 1, write accepted when fb_we & fb_ready.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; task_done, busy, fb_we, fb_addr, fb_data all 0.
  - Applies mid-operation too: the column is abandoned and no task_done is issued.
- States: IDLE -> DRAW -> DONE -> IDLE.
- IDLE:
  - task_start=1 is accepted. Latch the colours.
  - wh = min(wall_h, SCREEN_H).
  - top = (SCREEN_H - wh) >> 1 (odd remainder goes to the floor).
  - bot = top + wh.
  - y=0, addr=col_x. Enter DRAW.
- DRAW:
  - fb_we=1, fb_addr=addr, fb_data = ceil if y<top, wall if y<bot, else floor.
  - On fb_we & fb_ready: y+=1, addr+=SCREEN_W (no multiplier).
  - If the accepted write has y==SCREEN_H-1, enter DONE and drop fb_we.
  - While fb_ready=0, fb_addr, fb_data and fb_we hold stable.
- DONE: task_done=1 for exactly one cycle, then IDLE.
- busy=1 in DRAW and DONE; 0 in IDLE.
- task_start is ignored outside IDLE. No queuing; the synchroniser guarantees no overlap.
- Latency with fb_ready tied high:
  - Start at cycle 0.
  - Writes at cycles 1..SCREEN_H.
  - task_done at cycle SCREEN_H+1.
  - Next start accepted at cycle SCREEN_H+2.
- Boundaries:
  - wh=0 -> top=bot=SCREEN_H/2; no wall pixels.
  - wall_h>=SCREEN_H -> all wall.
  - col_x>=SCREEN_W is out of contract; addresses are computed unchecked.
  - No write is issued past row SCREEN_H-1.
- Arithmetic:
  - top, bot and y are 9 bits unsigned.
  - addr is ADDR_W bits; the maximum (SCREEN_W*SCREEN_H-1) never wraps.

Decomposition:
- Shared package raycaster_pkg:
  - SCREEN_W and SCREEN_H constants.
  - Colour width.
  - Draw state encoding (IDLE/DRAW/DONE).
- One natural sub-module: column_span_calc.
  - Combinational clamp plus top/bot computation from wall_h.
  - Registered into the latched parameters on start.

Test Plan:
1. Reset, then col_x=5, wall_h=100, colours C=0x11, W=0x22, F=0x33, fb_ready=1 -> 240 writes at addrs 5, 325, ..., 76485. Rows 0-69 =0x11, rows 70-169 =0x22, rows 170-239 =0x33. task_done exactly at cycle 241.
2. wall_h=0 and wall_h=300 -> rows 0-119 ceil and rows 120-239 floor; all 240 rows wall respectively. wall_h=101 -> top=69, bot=170.
3. fb_ready random ~50% duty -> fb_addr/fb_data stable while stalled. Exactly 240 accepted writes, in order. A single task_done after the last accept.
4. Second task_start mid-DRAW and during DONE -> ignored: no extra writes, no second task_done. Latched colours unaffected by input changes after the start.
5. rst_n low at row 50 -> next cycle fb_we=0 and busy=0. No task_done. A fresh start afterwards draws a complete 240-row column.
6. Back-to-back: start pulse on the cycle after task_done -> accepted. Second column draws correctly at its new col_x.

Source files
------------

// File: rtl/raycaster_pkg.sv
// Shared raycaster constants and the column-draw state encoding.
package raycaster_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int ADDR_W   = 17;
    localparam int COLOR_W  = 8;
    localparam int COORD_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } draw_state_e;

endpackage

// File: rtl/column_span_calc.sv
// Clamps the wall height to the screen and centres the wall span vertically.
module column_span_calc
    import raycaster_pkg::*;
#(
    parameter int SCREEN_H = raycaster_pkg::SCREEN_H
) (
    input  logic [COORD_W-1:0] wall_h,
    output logic [COORD_W-1:0] top,
    output logic [COORD_W-1:0] bot
);

    localparam logic [COORD_W-1:0] H_MAX = COORD_W'(SCREEN_H);

    logic [COORD_W-1:0] wh;
    logic [COORD_W-1:0] gap;

    // An odd leftover row goes to the floor, because the shift rounds top down.
    assign wh  = (wall_h > H_MAX) ? H_MAX : wall_h;
    assign gap = H_MAX - wh;
    assign top = gap >> 1;
    assign bot = top + wh;

endmodule

// File: rtl/column_draw_task.sv
// clkb-side task executor: on task_start, writes one screen column
// (ceiling, wall, floor) top to bottom into the framebuffer, then pulses task_done.
module column_draw_task
    import raycaster_pkg::*;
#(
    parameter int SCREEN_W = raycaster_pkg::SCREEN_W,
    parameter int SCREEN_H = raycaster_pkg::SCREEN_H,
    parameter int ADDR_W   = raycaster_pkg::ADDR_W,
    parameter int COLOR_W  = raycaster_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               task_start,
    output logic               task_done,
    output logic               busy,
    input  logic [8:0]         col_x,
    input  logic [8:0]         wall_h,
    input  logic [COLOR_W-1:0] ceil_color,
    input  logic [COLOR_W-1:0] wall_color,
    input  logic [COLOR_W-1:0] floor_color,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               fb_we,
    input  logic               fb_ready
);

    localparam logic [ADDR_W-1:0]  ROW_STRIDE = ADDR_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(SCREEN_H - 1);

    draw_state_e        state, state_nxt;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] top_q, bot_q;
    logic [COORD_W-1:0] top_c, bot_c;
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] ceil_q, wall_q, floor_q;
    logic               accept;
    logic               fire;

    column_span_calc #(.SCREEN_H(SCREEN_H)) u_span (
        .wall_h (wall_h),
        .top    (top_c),
        .bot    (bot_c)
    );

    assign accept = (state == ST_IDLE) && task_start;
    assign fire   = (state == ST_DRAW) && fb_ready;

    // NOTE: sequential state uses <= so every register sees pre-edge values;
    // the datapath registers are few and small, so all of them take the reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            y       <= '0;
            addr    <= '0;
            top_q   <= '0;
            bot_q   <= '0;
            ceil_q  <= '0;
            wall_q  <= '0;
            floor_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                y       <= '0;
                addr    <= ADDR_W'(col_x);
                top_q   <= top_c;
                bot_q   <= bot_c;
                ceil_q  <= ceil_color;
                wall_q  <= wall_color;
                floor_q <= floor_color;
            end else if (fire) begin
                y    <= y + 1'b1;
                addr <= addr + ROW_STRIDE;
            end
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        task_done = 1'b0;
        fb_we     = 1'b0;
        fb_addr   = '0;
        fb_data   = '0;
        unique case (state)
            ST_IDLE: begin
                if (task_start) state_nxt = ST_DRAW;
            end
            ST_DRAW: begin
                busy    = 1'b1;
                fb_we   = 1'b1;
                fb_addr = addr;
                if (y < top_q)      fb_data = ceil_q;
                else if (y < bot_q) fb_data = wall_q;
                else                fb_data = floor_q;
                if (fb_ready && (y == Y_LAST)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                task_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
